// File: rtl/nn_mac_if.sv
// Load, control and result-stream signals between the pin front end and nn_mac_sequencer.
interface nn_mac_if;
  logic       ld_valid;
  logic       ld_sel;
  logic [3:0] ld_nibble;
  logic       ld_ready;
  logic       clr_w;
  logic       clr_d;
  logic       start;
  logic       busy;
  logic       err;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;

  modport master (
    output ld_valid, ld_sel, ld_nibble, clr_w, clr_d, start, res_ready,
    input  ld_ready, busy, err, res_valid, res_data
  );

  modport slave (
    input  ld_valid, ld_sel, ld_nibble, clr_w, clr_d, start, res_ready,
    output ld_ready, busy, err, res_valid, res_data
  );
endinterface

// File: rtl/nn_mac_sequencer.sv
// Nibble-loaded weight/data registers, 16-step MAC through one shared 8x8 signed multiplier,
// four saturated 8-bit dot products drained over a valid/ready byte stream.
module nn_mac_sequencer #(
  parameter int SHIFT = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  nn_mac_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 18;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(128));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [31:0]               r_w;
  logic [127:0]              r_d;
  logic [3:0]                r_cnt_w;
  logic [5:0]                r_cnt_d;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_res [4];
  logic [3:0]                r_mac_idx;
  logic [1:0]                r_out_idx;
  logic                      r_err;

  logic                      w_idle;
  logic                      w_run;
  logic                      w_counts_full;
  logic                      w_start_ok;
  logic                      w_start_bad;
  logic                      w_ld_w;
  logic                      w_ld_d;
  logic                      w_last_mac;
  logic                      w_out_acc;
  logic                      w_last_out;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_data;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_sum;

  function automatic logic signed [ACC_W-1:0] arsh(input logic signed [ACC_W-1:0] a);
    return a >>> SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return a[DATA_W-1:0];
  endfunction

  always_comb begin
    w_idle        = (r_state == S_IDLE);
    w_run         = (r_state == S_RUN);
    w_counts_full = (r_cnt_w == 4'd8) && (r_cnt_d == 6'd32);
    // start is judged on the counts held before this edge, even if a load/clear lands now
    w_start_ok    = w_idle && bus.start && w_counts_full;
    w_start_bad   = w_idle && bus.start && !w_counts_full;
    w_ld_w        = w_idle && bus.ld_valid && !bus.ld_sel;
    w_ld_d        = w_idle && bus.ld_valid && bus.ld_sel;
    w_last_mac    = w_run && (r_mac_idx == 4'd15);
    w_out_acc     = (r_state == S_OUT) && bus.res_ready;
    w_last_out    = w_out_acc && (r_out_idx == 2'd3);
  end

  // Multiply stage: weight byte i mod 4 against data byte i
  always_comb begin
    w_coef = $signed(r_w[{r_mac_idx[1:0], 3'b000} +: COEF_W]);
    w_data = $signed(r_d[{r_mac_idx, 3'b000} +: DATA_W]);
    w_prod = w_coef * w_data;
    w_sum  = r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_mac) w_state_nxt = S_OUT;
      S_OUT:   if (w_last_out) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    case (r_state)
      S_IDLE: bus.ld_ready = 1'b1;
      S_RUN:  bus.busy = 1'b1;
      S_OUT: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = r_res[r_out_idx];
      end
      default: ;
    endcase
  end

  assign bus.err = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_start_bad;
  end

  // Weight register: clear beats a same-cycle load; extra nibbles shift but the count saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w     <= '0;
      r_cnt_w <= '0;
    end else if (bus.clr_w && w_idle) begin
      r_w     <= '0;
      r_cnt_w <= '0;
    end else if (w_ld_w) begin
      r_w <= {bus.ld_nibble, r_w[31:4]};
      if (r_cnt_w != 4'd8) r_cnt_w <= r_cnt_w + 4'd1;
    end
  end

  // Data register: count drops to zero on return to IDLE so each run needs fresh data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d     <= '0;
      r_cnt_d <= '0;
    end else if (bus.clr_d && w_idle) begin
      r_d     <= '0;
      r_cnt_d <= '0;
    end else if (w_ld_d) begin
      r_d <= {bus.ld_nibble, r_d[127:4]};
      if (r_cnt_d != 6'd32) r_cnt_d <= r_cnt_d + 6'd1;
    end else if (w_last_out) begin
      r_cnt_d <= '0;
    end
  end

  // Accumulate stage: every fourth step quantises the group sum and restarts from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mac_idx <= '0;
      for (int j = 0; j < 4; j++) r_res[j] <= '0;
    end else if (w_run) begin
      r_mac_idx <= r_mac_idx + 4'd1;
      if (r_mac_idx[1:0] == 2'd3) begin
        r_res[r_mac_idx[3:2]] <= sat8(arsh(w_sum));
        r_acc                 <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         r_out_idx <= '0;
    else if (w_out_acc) r_out_idx <= r_out_idx + 2'd1;
  end
endmodule

// File: doc/nn_mac_sequencer.md
Name: nn_mac_sequencer

Overview:
- Loads one 32-bit weight vector and one 128-bit data vector over a shared 4-bit nibble bus, then runs 16 multiply-accumulates through a single shared 8x8 signed multiplier.
- Produces four 8-bit saturated dot products (one per group of 4 data bytes) and returns them over a valid/ready byte stream.
- Sits between the pin-level serial load front end and the output pins; owns load sequencing, register clearing, compute scheduling and result draining.

Parameters:
- SHIFT, 0, arithmetic right shift applied to each 18-bit accumulator before saturation to 8 bits (legal 0..10).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- ld_valid  in  1  load nibble present
- ld_sel  in  1  load target: 0 = weight register, 1 = data register
- ld_nibble  in  4  load payload
- ld_ready  out  1  load accepted this cycle when high with ld_valid
- clr_w  in  1  clear weight register and its nibble count
- clr_d  in  1  clear data register and its nibble count
- start  in  1  request compute
- busy  out  1  high in RUN and OUT
- err  out  1  one-cycle pulse: start rejected
- res_valid  out  1  result byte valid
- res_data  out  8  result byte, signed two's complement
- res_ready  in  1  consumer accepts result

Behaviour:
- Reset: on posedge clk with rst_n=0: state IDLE; weight register, data register, nibble counts, accumulator, result registers, mac index, out index = 0. Outputs: ld_ready=1 (IDLE), busy=0, err=0, res_valid=0, res_data=0. Reset wins over everything and aborts any state.
- States:
  - IDLE: ld_ready=1.
  - RUN: 16 cycles.
  - OUT: drain 4 results.
- Load (IDLE only; ld_ready=0 in RUN/OUT):
  - On ld_valid&&ld_ready, the target register shifts right by 4, with ld_nibble entering the top nibble. After 8 weight nibbles, the first nibble sits in bits [3:0].
  - Counts: weight 0..8, data 0..32, saturating. Extra nibbles still shift.
  - Weight w[k] = W[8k+7:8k], k=0..3. Data d[i] = D[8i+7:8i], i=0..15.
- Clear: honoured only in IDLE. clr_w zeroes the weight register and count; clr_d does the same for data. If a clear and a load to the same target occur in the same cycle, the clear wins. Clear is ignored in RUN/OUT.
- start in IDLE:
  - If weight count==8 and data count==32: go to RUN next cycle.
  - Otherwise: err=1 for exactly one cycle, stay in IDLE.
  - If start coincides with a load or clear, the load or clear takes effect and start is evaluated against pre-cycle counts.
  - start is ignored when not IDLE.
- RUN cycle i (0..15): acc <= acc + w[i mod 4]*d[i].
  - acc is 18-bit signed; products are 16-bit signed and sign-extended.
  - When i mod 4 == 3, the completed sum for group j=i/4 is quantised and written to r[j], and acc restarts from 0, so the next cycle uses product only.
  - Quantise: t = acc_final >>> SHIFT, then saturate to [-128,127].
  - After i=15, go to OUT.
- OUT:
  - res_valid=1, res_data=r[n], n starting at 0. Data is held stable while res_ready=0.
  - On res_valid&&res_ready, n increments. Accepting n=3 goes to IDLE next cycle with res_valid=0.
- Latency: start sampled at edge T → busy=1 from T+1 → first res_valid at edge T+17. Minimum start-to-IDLE is 21 cycles with res_ready held high.
- On return to IDLE: data count is cleared to 0, so new data is required. Data register contents and weights with their count are retained for reuse.

Test Plan:
- Weights 0x01010101, data bytes 1..16 (d[0]=1), SHIFT=0, res_ready=1 → bytes 10, 26, 42, 58. First res_valid exactly 17 cycles after start, then IDLE 4 cycles later.
- All weights 0x7F and all data 0x7F (sum 64516) → four bytes 0x7F. All weights 0x80 with all data 0x7F (sum -65024) → four bytes 0x80.
- start with only 7 weight nibbles loaded → err pulse for 1 cycle, busy stays 0, no res_valid. Load the 8th nibble, start again → runs.
- res_ready low for 5 cycles on the second byte → res_data holds 26 throughout. ld_valid pulses during RUN/OUT → ld_ready=0 and registers unchanged.
- After one complete run, reload only data (32 nibbles of 0x02 bytes), start → bytes 8,8,8,8 (weights reused). start without reloading data → err.
- rst_n low for one cycle mid-RUN → IDLE next cycle, all counts 0, res_valid never asserts. clr_w together with a weight load in the same cycle → weight count 0.
